// File: rtl/sdp_msg_rx_pkg.sv
// Shared definitions for the SDP slave-message receiver: marker value,
// STATUS bit positions, error codes, FSM states and the header check.
package sdp_msg_rx_pkg;

    localparam logic [7:0] MARKER_SLAVE = 8'hA5;

    // STATUS byte bit positions
    localparam int unsigned ST_ERR_IN_MSG  = 0;
    localparam int unsigned ST_SERVICE_REQ = 1;
    localparam int unsigned ST_SD_BUSY     = 2;
    localparam int unsigned ST_DP_SENDING  = 4;

    localparam int unsigned BYTE_CNT_W = 11;

    typedef enum logic [2:0] {
        ERR_NONE     = 3'd0,
        ERR_BYTE     = 3'd1,
        ERR_LEN      = 3'd2,
        ERR_MISMATCH = 3'd3,
        ERR_TIMEOUT  = 3'd4
    } err_code_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STATUS,
        S_LEN_HI,
        S_LEN_LO,
        S_PAYLOAD
    } state_e;

    // Header validation in priority order: oversize length first, then the
    // dp_sending flag must agree with whether a payload follows.
    function automatic err_code_e hdr_check(input logic [15:0] len,
                                            input logic [7:0]  status,
                                            input logic [15:0] max_len);
        if (len > max_len)
            return ERR_LEN;
        if (status[ST_DP_SENDING] != (len != 16'd0))
            return ERR_MISMATCH;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/sdp_msg_rx_if.sv
// Byte-stream input and decoded-message output bundle of the SDP receiver.
interface sdp_msg_rx_if;

    logic [7:0]  d;
    logic        d_rdy;
    logic        d_err;
    logic [7:0]  q;
    logic        q_rdy;
    logic [7:0]  status;
    logic [15:0] len;
    logic        hdr_vld;
    logic        msg_end;
    logic        msg_err;
    logic [2:0]  err_code;
    logic        busy;

    // Decoder/host side: drives bytes, consumes decoded results
    modport master (
        output d, d_rdy, d_err,
        input  q, q_rdy, status, len, hdr_vld, msg_end, msg_err, err_code, busy
    );

    // Receiver side
    modport slave (
        input  d, d_rdy, d_err,
        output q, q_rdy, status, len, hdr_vld, msg_end, msg_err, err_code, busy
    );

endinterface

// File: rtl/sdp_rx_watchdog.sv
// Inter-byte watchdog: counter cleared by clr, expire flags the cycle in
// which the counter would reach TIMEOUT_CYC without a clear.
module sdp_rx_watchdog #(
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic expire
);

    localparam int unsigned  CW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    // Count idle cycles, saturating one short of the limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (cnt != LAST)
            cnt <= cnt + CW'(1);
    end

    // Expiry lands on the edge where the count reaches TIMEOUT_CYC; a clear wins
    always_comb begin
        expire = ~clr & (cnt == LAST);
    end

endmodule

// File: rtl/sdp_msg_rx.sv
// SDP slave-response parser: MARKER, STATUS, LEN_HI, LEN_LO, then LEN
// payload bytes. All outputs registered, strobes one cycle after d_rdy.
module sdp_msg_rx
    import sdp_msg_rx_pkg::*;
#(
    parameter logic [7:0]  MARKER      = MARKER_SLAVE,
    parameter int unsigned MAX_LEN     = 1024,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic         clk,
    input  logic         rst,
    sdp_msg_rx_if.slave  bus
);

    state_e                  state, state_nxt;
    logic [7:0]              q_r, q_n;
    logic                    q_rdy_r, q_rdy_n;
    logic                    hdr_r, hdr_n;
    logic                    end_r, end_n;
    logic                    merr_r, merr_n;
    logic                    busy_r, busy_n;
    logic [7:0]              status_r, status_n;
    logic [15:0]             len_r, len_n;
    logic [BYTE_CNT_W-1:0]   cnt_r, cnt_n;
    err_code_e               err_r, err_n;

    logic        wd_clr, wd_expire;
    logic        byte_ok, byte_bad, timeout, last_byte, is_marker;
    logic [15:0] len_full;
    err_code_e   hdr_err;

    sdp_rx_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .expire (wd_expire)
    );

    // Watchdog is held clear while idle and restarted by every byte
    always_comb begin
        wd_clr = bus.d_rdy | (state == S_IDLE);
    end

    // Decode the current byte event; a byte always beats a coincident timeout
    always_comb begin
        byte_ok   = bus.d_rdy & ~bus.d_err;
        byte_bad  = bus.d_rdy & bus.d_err & (state != S_IDLE);
        timeout   = wd_expire & (state != S_IDLE);
        is_marker = byte_ok & (bus.d == MARKER);
        len_full  = {len_r[15:8], bus.d};
        hdr_err   = hdr_check(len_full, status_r, 16'(MAX_LEN));
        last_byte = ({5'b0, cnt_r + 11'd1} == len_r);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (state == S_IDLE) begin
            if (is_marker)
                state_nxt = S_STATUS;
        end else if (byte_bad || timeout) begin
            state_nxt = S_IDLE;
        end else if (byte_ok) begin
            case (state)
                S_STATUS:  state_nxt = S_LEN_HI;
                S_LEN_HI:  state_nxt = S_LEN_LO;
                S_LEN_LO:  state_nxt = (hdr_err == ERR_NONE && len_full != 16'd0) ? S_PAYLOAD : S_IDLE;
                S_PAYLOAD: state_nxt = last_byte ? S_IDLE : S_PAYLOAD;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Output/datapath next values; every error path funnels into msg_err
    always_comb begin
        q_n      = q_r;
        q_rdy_n  = 1'b0;
        hdr_n    = 1'b0;
        end_n    = 1'b0;
        merr_n   = 1'b0;
        status_n = status_r;
        len_n    = len_r;
        cnt_n    = cnt_r;
        err_n    = err_r;
        if (state == S_IDLE) begin
            if (is_marker)
                err_n = ERR_NONE;
        end else if (byte_bad) begin
            err_n  = ERR_BYTE;
            merr_n = 1'b1;
        end else if (timeout) begin
            err_n  = ERR_TIMEOUT;
            merr_n = 1'b1;
        end else if (byte_ok) begin
            case (state)
                S_STATUS: status_n = bus.d;
                S_LEN_HI: len_n[15:8] = bus.d;
                S_LEN_LO: begin
                    len_n = len_full;
                    cnt_n = '0;
                    if (hdr_err != ERR_NONE) begin
                        err_n  = hdr_err;
                        merr_n = 1'b1;
                    end else begin
                        hdr_n = 1'b1;
                        end_n = (len_full == 16'd0);
                    end
                end
                S_PAYLOAD: begin
                    q_n     = bus.d;
                    q_rdy_n = 1'b1;
                    cnt_n   = cnt_r + 11'd1;
                    end_n   = last_byte;
                end
                default: ;
            endcase
        end
        busy_n = (state_nxt != S_IDLE);
    end

    // Output and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r      <= '0;
            q_rdy_r  <= 1'b0;
            hdr_r    <= 1'b0;
            end_r    <= 1'b0;
            merr_r   <= 1'b0;
            busy_r   <= 1'b0;
            status_r <= '0;
            len_r    <= '0;
            cnt_r    <= '0;
            err_r    <= ERR_NONE;
        end else begin
            q_r      <= q_n;
            q_rdy_r  <= q_rdy_n;
            hdr_r    <= hdr_n;
            end_r    <= end_n;
            merr_r   <= merr_n;
            busy_r   <= busy_n;
            status_r <= status_n;
            len_r    <= len_n;
            cnt_r    <= cnt_n;
            err_r    <= err_n;
        end
    end

    assign bus.q        = q_r;
    assign bus.q_rdy    = q_rdy_r;
    assign bus.hdr_vld  = hdr_r;
    assign bus.msg_end  = end_r;
    assign bus.msg_err  = merr_r;
    assign bus.busy     = busy_r;
    assign bus.status   = status_r;
    assign bus.len      = len_r;
    assign bus.err_code = err_r;

endmodule

// File: tb/tb_sdp_msg_rx.sv
// Testbench for sdp_msg_rx: randomized byte timing against a message-level
// reference model; every cycle's full output vector is compared.
module tb_sdp_msg_rx;

    localparam int         MAXL = 16;
    localparam int         TMO  = 32;
    localparam logic [7:0] MK   = 8'hA5;

    typedef logic [39:0] snap_t;
    typedef logic [7:0]  byte_q_t[$];

    logic clk = 1'b0;
    logic rst;

    sdp_msg_rx_if bus();

    sdp_msg_rx #(
        .MARKER      (MK),
        .MAX_LEN     (MAXL),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    snap_t obs_q[$];
    snap_t exp_q[$];

    // reference model: position within the message, not an FSM
    bit          m_in;
    int          m_pos;
    int          m_idle;
    logic [7:0]  m_status;
    logic [7:0]  m_q;
    logic [15:0] m_len;
    logic [2:0]  m_err;
    logic        e_qrdy, e_hdr, e_end, e_merr;

    // layout: q_rdy q hdr end err code busy status len
    function automatic snap_t dut_snap();
        return {bus.q_rdy, bus.q, bus.hdr_vld, bus.msg_end, bus.msg_err,
                bus.err_code, bus.busy, bus.status, bus.len};
    endfunction

    function automatic snap_t mdl_snap();
        return {e_qrdy, m_q, e_hdr, e_end, e_merr, m_err, m_in, m_status, m_len};
    endfunction

    task automatic model_reset();
        m_in = 0; m_pos = 0; m_idle = 0;
        m_status = '0; m_q = '0; m_len = '0; m_err = '0;
        e_qrdy = 0; e_hdr = 0; e_end = 0; e_merr = 0;
    endtask

    task automatic model_step(input bit v, input logic [7:0] dv, input bit ev);
        e_qrdy = 0; e_hdr = 0; e_end = 0; e_merr = 0;
        if (!m_in) begin
            m_idle = 0;
            if (v && !ev && dv == MK) begin
                m_in = 1; m_pos = 1; m_err = 0;
            end
        end else if (v && ev) begin
            m_err = 1; e_merr = 1; m_in = 0;
        end else if (v) begin
            m_idle = 0;
            m_pos++;
            if (m_pos == 2) m_status = dv;
            else if (m_pos == 3) m_len[15:8] = dv;
            else if (m_pos == 4) begin
                m_len[7:0] = dv;
                if (int'(m_len) > MAXL) begin
                    m_err = 2; e_merr = 1; m_in = 0;
                end else if (m_status[4] != (m_len != 0)) begin
                    m_err = 3; e_merr = 1; m_in = 0;
                end else begin
                    e_hdr = 1;
                    if (m_len == 0) begin e_end = 1; m_in = 0; end
                end
            end else begin
                m_q = dv; e_qrdy = 1;
                if (m_pos == 4 + int'(m_len)) begin e_end = 1; m_in = 0; end
            end
        end else begin
            m_idle++;
            if (m_idle == TMO) begin m_err = 4; e_merr = 1; m_in = 0; end
        end
    endtask

    // one clock: drive inputs, advance the model, record DUT and model vectors
    task automatic step(input bit v, input logic [7:0] dv, input bit ev);
        bus.d_rdy = v;
        bus.d     = v ? dv : 8'($urandom);
        bus.d_err = ev;
        model_step(v, dv, ev);
        @(posedge clk);
        #1;
        obs_q.push_back(dut_snap());
        exp_q.push_back(mdl_snap());
        bus.d_rdy = 1'b0;
        bus.d_err = 1'b0;
    endtask

    task automatic send(input byte_q_t b, input int max_gap);
        foreach (b[i]) begin
            repeat ($urandom_range(0, max_gap)) step(0, 8'h00, 0);
            step(1, b[i], 0);
        end
    endtask

    task automatic test_reset();
        snap_t s;
        bus.d = '0; bus.d_rdy = 0; bus.d_err = 0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        s = dut_snap();
        checks++;
        if (s !== '0) begin failures++; $display("FAIL reset_state got=%h exp=0", s); end
        rst = 1'b0;
        repeat (2) step(0, 8'h00, 0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL reset_idle cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_basic();
        int nq = 0, ne = 0;
        send('{8'hA5, 8'h10, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33}, 3);
        repeat (2) step(0, 8'h00, 0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL basic cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
            nq += int'(obs_q[i][39]);
            ne += int'(obs_q[i][29]);
            if (obs_q[i][29]) begin
                checks++;
                if (obs_q[i][39:31] !== {1'b1, 8'h33}) begin failures++; $display("FAIL basic_end_q got=%h exp=133", obs_q[i][39:31]); end
            end
        end
        checks++;
        if (nq != 3 || ne != 1) begin failures++; $display("FAIL basic_counts got q=%0d end=%0d exp q=3 end=1", nq, ne); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_resync_zero_len();
        send('{8'h00, 8'h7F, 8'hA5, 8'h02, 8'h00, 8'h00}, 2);
        repeat (2) step(0, 8'h00, 0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL resync cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_len_err();
        send('{8'hA5, 8'h10, 8'h00, 8'h20}, 1);
        step(0, 8'h00, 0);
        checks++;
        if (bus.err_code !== 3'd2) begin failures++; $display("FAIL len_err_code got=%0d exp=2", bus.err_code); end
        send('{8'hA5, 8'h10, 8'h00, 8'h01, 8'hEE}, 1);
        send('{8'hA5, 8'h10, 8'h01, 8'h00}, 1);
        send('{8'hA5, 8'h10, 8'h00, 8'h11}, 1);
        send('{8'hA5, 8'h10, 8'h00, 8'h10}, 0);
        for (int i = 0; i < MAXL; i++) step(1, (i == 3) ? MK : 8'($urandom), 0);
        repeat (2) step(0, 8'h00, 0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL len_err cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mismatch();
        send('{8'hA5, 8'h00, 8'h00, 8'h02}, 2);
        step(0, 8'h00, 0);
        checks++;
        if (bus.err_code !== 3'd3) begin failures++; $display("FAIL mismatch_a got=%0d exp=3", bus.err_code); end
        send('{8'hA5, 8'h10, 8'h00, 8'h00}, 2);
        step(0, 8'h00, 0);
        checks++;
        if (bus.err_code !== 3'd3) begin failures++; $display("FAIL mismatch_b got=%0d exp=3", bus.err_code); end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL mismatch cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_timeout();
        int nerr = 0;
        send('{8'hA5, 8'h10, 8'h00, 8'h04, 8'h01}, 1);
        repeat (TMO) step(0, 8'h00, 0);
        checks++;
        if (bus.msg_err !== 1'b1 || bus.err_code !== 3'd4 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_fire got err=%b code=%0d busy=%b exp err=1 code=4 busy=0", bus.msg_err, bus.err_code, bus.busy);
        end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL timeout cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
        send('{8'hA5, 8'h10, 8'h00, 8'h01}, 0);
        repeat (TMO - 1) step(0, 8'h00, 0);
        step(1, 8'h5A, 0);
        step(0, 8'h00, 0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL timeout_race cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
            nerr += int'(obs_q[i][28]);
        end
        checks++;
        if (nerr != 0) begin failures++; $display("FAIL timeout_race_err got=%0d exp=0", nerr); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_byte_err();
        int nq = 0;
        send('{8'hA5, 8'h10, 8'h00, 8'h04, 8'h01}, 2);
        step(1, 8'h02, 1);
        step(1, 8'h03, 0);
        step(0, 8'h00, 0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL byte_err cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
            nq += int'(obs_q[i][39]);
        end
        checks++;
        if (nq != 1 || bus.err_code !== 3'd1) begin failures++; $display("FAIL byte_err_sum got q=%0d code=%0d exp q=1 code=1", nq, bus.err_code); end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_mid();
        snap_t s;
        send('{8'hA5, 8'h10, 8'h00, 8'h04, 8'h01, 8'h02}, 1);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_mid_pre cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
        #2 rst = 1'b1;
        #1 s = dut_snap();
        checks++;
        if (s !== '0) begin failures++; $display("FAIL rst_mid_async got=%h exp=0", s); end
        bus.d_rdy = 1'b1; bus.d = 8'h03;
        repeat (2) begin
            @(posedge clk);
            #1 s = dut_snap();
            checks++;
            if (s !== '0) begin failures++; $display("FAIL rst_mid_hold got=%h exp=0", s); end
        end
        bus.d_rdy = 1'b0;
        rst = 1'b0;
        model_reset();
        step(1, 8'h04, 0);
        repeat (3) step(0, 8'h00, 0);
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_mid_post cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0] st, b;
        logic [15:0] ln;
        bit ev;
        for (int m = 0; m < 40; m++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom);
                if (b == MK) b = 8'h00;
                step(1, b, 0);
            end
            ln = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, MAXL + 2));
            st = 8'($urandom);
            st[4] = (ln != 0);
            if ($urandom_range(0, 5) == 0) st[4] = ~st[4];
            for (int i = 0; i < 4 + int'(ln) && i < 4 + MAXL + 2; i++) begin
                if ($urandom_range(0, 29) == 0) repeat (TMO + 1) step(0, 8'h00, 0);
                else repeat ($urandom_range(0, 2)) step(0, 8'h00, 0);
                case (i)
                    0: b = MK;
                    1: b = st;
                    2: b = ln[15:8];
                    3: b = ln[7:0];
                    default: b = 8'($urandom);
                endcase
                ev = ($urandom_range(0, 49) == 0);
                step(1, b, ev);
            end
            repeat (TMO + 1) step(0, 8'h00, 0);
        end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL random cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]); end
        end
        obs_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resync_zero_len();
        test_len_err();
        test_mismatch();
        test_timeout();
        test_byte_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
